eep_i2c_master: RTL and testbench
=================================

# eep_i2c_master

I2C bus initiator for 24Cxx-family serial EEPROMs; the master-side counterpart of the mapper EEPROM responder model. It accepts single-byte read or write commands over a request/done handshake and drives open-drain SCL/SDA with START, address, data, ACK/NACK and STOP sequencing. It sits between mapper or save-state logic and a physical or emulated EEPROM. It selects frame format by `bram_type`, using the same encoding as the responder: X24C01 device-less framing, or 24C01/24C02 device-address framing.

## Interface
- `CLK_DIV`, default 50: clk cycles per quarter-bit phase; legal range ≥2.
- `clk  in  1`: system clock; all logic on rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `bram_type  in  4`: 0 = off, 3 = X24C01, 4 = 24C01, 5 = 24C02; other values are treated as off. Sampled at command accept.
- `cmd_req  in  1`: command strobe; accepted on an edge where `busy`=0.
- `cmd_we  in  1`: 1 = byte write, 0 = random read.
- `cmd_addr  in  8`: word address. Bit 7 is ignored for types 3 and 4.
- `cmd_dat  in  8`: write data.
- `busy  out  1`: transaction in progress.
- `done  out  1`: one-cycle pulse at transaction end.
- `nack  out  1`: last transaction aborted on a missing ACK, or type was off. Held until the next accept.
- `rd_dat  out  8`: read result. Updated only on a successful read.
- `scl_out  out  1`: 0 = drive low, 1 = release.
- `sda_out  out  1`: 0 = drive low, 1 = release.
- `sda_in  in  1`: bus SDA level. Synchronised internally through 2 flops.

## Operation
- Reset: `scl_out`=1, `sda_out`=1, `busy`=0, `done`=0, `nack`=0, `rd_dat`=0, FSM = IDLE.
- Accept: latch `cmd_*` and `bram_type`, clear `nack`, set `busy` on the same edge.
- If the latched type is off: go straight to FIN, no bus activity, `nack`=1.
- FSM states:
  - IDLE → START → TXBYTE → ACKRX → (next TXBYTE | RSTART | RXBYTE | STOP).
  - RXBYTE → ACKTX → STOP → FIN → IDLE.
- Frame per type (bytes MSB first):
  - 24C01/02 write: S, A0, addr, data, P.
  - 24C01/02 read: S, A0, addr, Sr, A1, rx byte + master NACK, P.
  - X24C01 write: S, {addr[6:0],0}, data, P.
  - X24C01 read: S, {addr[6:0],1}, rx byte + master NACK, P.
- ACKRX: `sda_in`=1 sets `nack`, skips the remaining bytes, then STOP and FIN. `rd_dat` is unchanged.
- RXBYTE: release SDA, shift `sda_in` MSB first. Copy to `rd_dat` at the ACKTX state.
- FIN: `done`=1 for one cycle, `busy`=0 on the same edge. A new `cmd_req` is accepted on the next edge.
- `cmd_req` while `busy`=1 is ignored, not queued.
- The write-cycle (tWR) delay is not handled; the caller spaces writes.
- Clock stretching is not supported.

## Timing
- Each phase lasts exactly `CLK_DIV` clks. A bit, START, Sr and STOP each take 4 phases p0–p3.
- Data bit:
  - p0: SCL=0, SDA driven to the new value.
  - p1–p2: SCL=1.
  - p3: SCL=0.
  - `sda_in` is sampled on the last clk of p1.
- START (from idle):
  - p0–p1: SDA=1, SCL=1.
  - p2: SDA=0, SCL=1.
  - p3: SDA=0, SCL=0.
- Sr (from SCL low):
  - p0: SDA=1, SCL=0.
  - p1: SDA=1, SCL=1.
  - p2: SDA=0, SCL=1.
  - p3: SDA=0, SCL=0.
- STOP:
  - p0: SDA=0, SCL=0.
  - p1: SDA=0, SCL=1.
  - p2–p3: SDA=1, SCL=1.
- SDA never changes while SCL=1, except for START, Sr and STOP edges.
- Latency, counted from the accept edge to `done` = N×`CLK_DIV` + 1 clks, where N is:
  - 116 for a 24C0x write.
  - 156 for a 24C0x read.
  - 80 for an X24C01 write or read.
  - An abort at ACK k: 4 + 36k + 4.
- Type-off latency: `done` 1 clk after accept.
- Outputs are registered; no combinational path from `sda_in` to the outputs.
- Reset mid-transaction: lines are released asynchronously, no STOP is issued, `busy`=0. The next command starts with a START.

## Test plan
- Reset with `CLK_DIV`=4 → SCL=SDA=1, `busy`=0, `done`=0, `rd_dat`=00.
- 24C02 write: addr 3C, data 5A, with a responder model ACKing → bus carries A0, 3C, 5A; `done` at 116×4+1 clks; `nack`=0.
- 24C02 read: addr 10, model returns C3 → bus carries A0, 10, Sr, A1; master NACKs on the 9th bit; `rd_dat`=C3 at `done` (156×4+1).
- X24C01 read: addr 85 → first byte 0B (bit 7 dropped, R=1); `done` at 80×4+1.
- No responder (SDA floats 1): write command → `nack`=1 after the first byte; STOP issued; `done` at 44×4+1; `rd_dat` unchanged.
- Two commands:
  - `cmd_req` during `busy` → ignored.
  - `bram_type`=0 command → `done` after 1 clk with `nack`=1 and no SCL toggles.
  - `rst_n` pulled low mid-byte → SCL=SDA=1 immediately.

Source files
------------

// File: rtl/eep_i2c_master.sv
// eep_i2c_master: single-byte 24Cxx/X24C01 EEPROM I2C initiator with open-drain SCL/SDA
module eep_i2c_master #(
  parameter int CLK_DIV = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] bram_type,
  input  logic       cmd_req,
  input  logic       cmd_we,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_dat,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic [7:0] rd_dat,
  output logic       scl_out,
  output logic       sda_out,
  input  logic       sda_in
);
  localparam int CW = $clog2(CLK_DIV);
  typedef enum logic [3:0] {IDLE, START, TXBYTE, ACKRX, RSTART, RXBYTE, ACKTX, STOP, FIN} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [1:0] ph, bcnt;
  logic [2:0] bi;
  logic [7:0] tx, rx, addr, dat;
  logic we, dev, ackb, s1, s2, scl_c, sda_c;
  logic tick, last, samp, hi, on, cmd_dev, more, rs, idle;
  assign tick = cnt == CW'(CLK_DIV - 1);
  assign last = tick && ph == 2'd3;
  assign samp = tick && ph == 2'd1;
  assign hi = ph[0] ^ ph[1];
  assign on = bram_type inside {4'd3, 4'd4, 4'd5};
  assign cmd_dev = bram_type inside {4'd4, 4'd5};
  assign idle = state == IDLE || state == FIN;
  // bcnt indexes the byte just acknowledged: decides whether more address/data bytes follow
  assign more = dev ? (bcnt == 2'd0 || (bcnt == 2'd1 && we)) : (bcnt == 2'd0 && we);
  assign rs = dev && bcnt == 2'd1 && !we;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:          if (cmd_req) nxt = on ? START : FIN;
      START, RSTART: if (last) nxt = TXBYTE;
      TXBYTE:        if (last && bi == 3'd7) nxt = ACKRX;
      ACKRX:         if (last) nxt = ackb ? STOP : more ? TXBYTE : rs ? RSTART : we ? STOP : RXBYTE;
      RXBYTE:        if (last && bi == 3'd7) nxt = ACKTX;
      ACKTX:         if (last) nxt = STOP;
      STOP:          if (last) nxt = FIN;
      default:       nxt = IDLE;
    endcase
  end
  always_comb begin
    scl_c = 1'b1;
    sda_c = 1'b1;
    case (state)
      START:                begin scl_c = ph != 2'd3; sda_c = !ph[1]; end
      RSTART:               begin scl_c = hi; sda_c = !ph[1]; end
      TXBYTE:               begin scl_c = hi; sda_c = tx[7]; end
      ACKRX, RXBYTE, ACKTX: scl_c = hi;
      STOP:                 begin scl_c = ph != 2'd0; sda_c = ph[1]; end
      default:              ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0; ph <= '0; bi <= '0; bcnt <= '0;
      tx <= '0; rx <= '0; addr <= '0; dat <= '0;
      we <= 1'b0; dev <= 1'b0; ackb <= 1'b1; s1 <= 1'b1; s2 <= 1'b1;
      busy <= 1'b0; done <= 1'b0; nack <= 1'b0; rd_dat <= '0;
      scl_out <= 1'b1; sda_out <= 1'b1;
    end else begin
      s1 <= sda_in;
      s2 <= s1;
      scl_out <= scl_c;
      sda_out <= sda_c;
      done <= 1'b0;
      cnt <= (idle || tick) ? '0 : cnt + CW'(1);
      if (tick) ph <= ph + 2'd1;
      if (state == IDLE && cmd_req) begin
        busy <= 1'b1;
        nack <= !on;
        we <= cmd_we;
        dev <= cmd_dev;
        addr <= {cmd_addr[7] & (bram_type == 4'd5), cmd_addr[6:0]};
        dat <= cmd_dat;
        bcnt <= '0;
        bi <= '0;
        tx <= cmd_dev ? 8'hA0 : {cmd_addr[6:0], !cmd_we};
      end
      if (last && (state == TXBYTE || state == RXBYTE)) bi <= bi + 3'd1;
      if (last && state == TXBYTE) tx <= {tx[6:0], 1'b0};
      if (samp && state == RXBYTE) rx <= {rx[6:0], s2};
      if (samp && state == ACKRX) ackb <= s2;
      // preload the following byte unconditionally; unused when the frame turns around or stops
      if (last && state == ACKRX) begin
        nack <= ackb;
        bcnt <= bcnt + 2'd1;
        tx <= (dev && bcnt == 2'd0) ? addr : dat;
      end
      if (last && state == RSTART) tx <= 8'hA1;
      if (last && state == RXBYTE && bi == 3'd7) rd_dat <= rx;
      if (state == FIN) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_eep_i2c_master.sv
// tb_eep_i2c_master: table-driven bench with an EEPROM responder model on the open-drain bus
module tb_eep_i2c_master;
  localparam int D = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] bram_type = '0;
  logic cmd_req = 1'b0, cmd_we = 1'b0;
  logic [7:0] cmd_addr = '0, cmd_dat = '0, rd_dat;
  logic busy, done, nack, scl_out, sda_out, sda_in;
  logic drv = 1'b1;
  assign sda_in = sda_out & drv;
  always #5 clk = ~clk;
  eep_i2c_master #(.CLK_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .bram_type(bram_type), .cmd_req(cmd_req), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_dat(cmd_dat), .busy(busy), .done(done), .nack(nack),
    .rd_dat(rd_dat), .scl_out(scl_out), .sda_out(sda_out), .sda_in(sda_in)
  );
  int checks = 0, errors = 0;
  logic resp_en = 1'b1;
  logic [7:0] resp_dat = '0, sh = '0;
  logic [7:0] lg [8];
  int nlog = 0, nstart = 0, nfall = 0, bitc = 0;
  logic pscl = 1'b1, psda = 1'b1, bs, first = 1'b0, tx_mode = 1'b0, pend = 1'b0, mack = 1'b0;
  // responder: logs master bytes, ACKs when enabled, serves resp_dat after a read-address byte
  always @(negedge clk) begin
    bs = sda_out & drv;
    if (!rst_n) begin
      bitc = 0; drv = 1'b1; tx_mode = 1'b0; pend = 1'b0;
    end else if (pscl && scl_out && psda && !bs) begin
      bitc = 0; first = 1'b1; tx_mode = 1'b0; pend = 1'b0; drv = 1'b1; nstart++;
    end else if (pscl && scl_out && !psda && bs) begin
      bitc = 0; drv = 1'b1;
    end else if (!pscl && scl_out) begin
      if (bitc < 8) sh = {sh[6:0], bs};
      else mack = bs;
      bitc++;
    end else if (pscl && !scl_out) begin
      nfall++;
      if (bitc == 8 && tx_mode) drv = 1'b1;
      else if (bitc == 8) begin
        if (nlog < 8) lg[nlog] = sh;
        nlog++;
        drv = !resp_en;
        pend = first && sh[0] && resp_en;
        first = 1'b0;
      end else if (bitc == 9) begin
        bitc = 0;
        tx_mode = pend;
        pend = 1'b0;
        drv = tx_mode ? resp_dat[7] : 1'b1;
      end else if (tx_mode) drv = resp_dat[7-bitc];
    end
    pscl = scl_out;
    psda = sda_out & drv;
  end
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  typedef struct {
    logic [3:0] typ; logic we; logic [7:0] addr, dat; logic en; logic [7:0] rdat;
    int n; logic nk; int nb; logic [23:0] bytes; int ns; logic poke;
  } vec_t;
  vec_t v [10];
  logic [7:0] exp_rd = '0;
  task automatic run(input vec_t t, input string nm);
    int lat;
    nlog = 0; nstart = 0; nfall = 0; mack = 1'b0;
    resp_en = t.en; resp_dat = t.rdat;
    @(negedge clk);
    bram_type = t.typ; cmd_we = t.we; cmd_addr = t.addr; cmd_dat = t.dat; cmd_req = 1'b1;
    @(posedge clk);
    #1 cmd_req = 1'b0;
    check({nm, " busy_set"}, busy, 1);
    lat = 0;
    while (!done && lat < 2000) begin
      @(posedge clk);
      #1 lat++;
      if (t.poke && lat == 40) begin cmd_req = 1'b1; bram_type = 4'd0; end
      if (t.poke && lat == 44) begin cmd_req = 1'b0; bram_type = t.typ; end
    end
    if (!t.we && !t.nk) exp_rd = t.rdat;
    check({nm, " latency"}, lat, t.n * D + 1);
    check({nm, " nack"}, nack, t.nk);
    check({nm, " busy_clr"}, busy, 0);
    check({nm, " rd_dat"}, rd_dat, exp_rd);
    check({nm, " nbytes"}, nlog, t.nb);
    for (int i = 0; i < t.nb && i < 3; i++) check($sformatf("%s byte%0d", nm, i), lg[i], t.bytes[23-8*i -: 8]);
    check({nm, " starts"}, nstart, t.ns);
    check({nm, " scl_falls"}, nfall, t.n == 0 ? 0 : t.n / 4 - 1);
    if (!t.we && !t.nk) check({nm, " master_nack"}, mack, 1);
    @(posedge clk);
    #1 check({nm, " done_pulse"}, done, 0);
  endtask
  initial begin
    v[0] = '{4'd5, 1'b1, 8'h3C, 8'h5A, 1'b1, 8'h00, 116, 1'b0, 3, 24'hA03C5A, 1, 1'b0};
    v[1] = '{4'd5, 1'b0, 8'h10, 8'h00, 1'b1, 8'hC3, 156, 1'b0, 3, 24'hA010A1, 2, 1'b0};
    v[2] = '{4'd3, 1'b0, 8'h85, 8'h00, 1'b1, 8'hE7, 80, 1'b0, 1, 24'h0B0000, 1, 1'b0};
    v[3] = '{4'd5, 1'b1, 8'h3C, 8'h5A, 1'b0, 8'h00, 44, 1'b1, 1, 24'hA00000, 1, 1'b0};
    v[4] = '{4'd4, 1'b1, 8'h9C, 8'h11, 1'b1, 8'h00, 116, 1'b0, 3, 24'hA01C11, 1, 1'b0};
    v[5] = '{4'd3, 1'b1, 8'h22, 8'h66, 1'b1, 8'h00, 80, 1'b0, 2, 24'h446600, 1, 1'b0};
    v[6] = '{4'd0, 1'b1, 8'h3C, 8'h5A, 1'b1, 8'h00, 0, 1'b1, 0, 24'h000000, 0, 1'b0};
    v[7] = '{4'd7, 1'b0, 8'h10, 8'h00, 1'b1, 8'h99, 0, 1'b1, 0, 24'h000000, 0, 1'b0};
    v[8] = '{4'd5, 1'b1, 8'h3C, 8'h5A, 1'b1, 8'h00, 116, 1'b0, 3, 24'hA03C5A, 1, 1'b1};
    v[9] = '{4'd4, 1'b0, 8'h9C, 8'h00, 1'b0, 8'h00, 44, 1'b1, 1, 24'hA00000, 1, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    check("reset scl", scl_out, 1);
    check("reset sda", sda_out, 1);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset nack", nack, 0);
    check("reset rd_dat", rd_dat, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 10; i++) run(v[i], $sformatf("row%0d", i));
    @(negedge clk);
    bram_type = 4'd5; cmd_we = 1'b1; cmd_addr = 8'h3C; cmd_dat = 8'h5A; cmd_req = 1'b1;
    @(posedge clk);
    #1 cmd_req = 1'b0;
    repeat (20) @(posedge clk);
    for (int k = 0; k < 200 && (scl_out || sda_out); k++) @(posedge clk);
    #2 check("midrst pre_scl_low", scl_out, 0);
    rst_n = 1'b0;
    #1;
    check("midrst scl", scl_out, 1);
    check("midrst sda", sda_out, 1);
    check("midrst busy", busy, 0);
    exp_rd = '0;
    @(negedge clk) rst_n = 1'b1;
    run(v[0], "after_rst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
